// File: rtl/store_line_serializer_pkg.sv
// Purpose : shared beat-level constants, beat word layout and FSM encodings for the store line serializer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package store_line_serializer_pkg;

   localparam int BEAT_DATA_W = 64;
   localparam int BEAT_MASK_W = 8;

   // Beat queue word layout: data in the upper bits, byte mask in the lower bits.
   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic [BEAT_MASK_W-1:0] mask;
   } beat_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // A beat carries bytes when any of its byte enables is set.
   function automatic logic beat_has_bytes(input logic [BEAT_MASK_W-1:0] m);
      return |m;
   endfunction

endpackage

// File: rtl/store_line_next_beat.sv
// Purpose : combinational find-next-set over per-beat flags, starting above (or at) a given index.
// Latency : purely combinational.
// Backpressure: none; pure function of its inputs.
// Ports   : flags   - one bit per beat, set when the beat is emittable
//           idx     - search origin
//           inclusive - when 1 the origin itself is a candidate, otherwise only beats above it
//           next_idx  - lowest qualifying beat (0 when none)
//           none_left - no qualifying beat exists
module store_line_next_beat #(
   parameter int BEATS = 4,
   parameter int IW    = $clog2(BEATS)
) (
   input  logic [BEATS-1:0] flags,
   input  logic [IW-1:0]    idx,
   input  logic             inclusive,
   output logic [IW-1:0]    next_idx,
   output logic             none_left
);

   // Scan from the top down so the lowest qualifying beat is the final assignment.
   always_comb begin
      next_idx  = '0;
      none_left = 1'b1;
      for (int i = BEATS-1; i >= 0; i--) begin
         if (flags[i] && ((i > int'(idx)) || (inclusive && (i == int'(idx))))) begin
            next_idx  = IW'(i);
            none_left = 1'b0;
         end
      end
   end

endmodule

// File: rtl/store_line_serializer.sv
// Purpose : captures a store line and emits it as 64-bit beats in ascending order, optionally skipping empty beats.
// Latency : first beat valid the cycle after line acceptance; lines may follow back-to-back with no bubble.
// Backpressure: io_deq_ready low holds the current beat stable; a new line is accepted only while idle or on the last beat handshake.
// Ports   : clock/reset (async active-low); io_req_* line request (valid/ready);
//           io_deq_* beat output (valid/ready) feeding the beat queue; io_done end-of-line pulse.
module store_line_serializer
   import store_line_serializer_pkg::*;
#(
   parameter int BEATS      = 4,
   parameter int SKIP_EMPTY = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         io_req_ready,
   input  logic                         io_req_valid,
   input  logic [BEAT_DATA_W*BEATS-1:0] io_req_bits_data,
   input  logic [BEAT_MASK_W*BEATS-1:0] io_req_bits_mask,
   input  logic                         io_deq_ready,
   output logic                         io_deq_valid,
   output logic [BEAT_MASK_W-1:0]       io_deq_bits_mask,
   output logic [BEAT_DATA_W-1:0]       io_deq_bits_data,
   output logic                         io_done
);

   localparam int IW = $clog2(BEATS);

   logic [0:0]                   state_q;
   logic [IW-1:0]                idx_q;
   logic [BEAT_DATA_W*BEATS-1:0] line_data_q;
   logic [BEAT_MASK_W*BEATS-1:0] line_mask_q;

   logic [BEATS-1:0] line_flags;
   logic [BEATS-1:0] req_flags;
   logic [IW-1:0]    next_idx;
   logic             last_beat;
   logic [IW-1:0]    first_idx;
   logic             req_empty;
   logic             beat_hs;
   logic             last_hs;
   logic             accept;
   beat_t            cur_beat;

   // Without skipping every beat is emittable, so the searches reduce to idx+1 / beat 0.
   always_comb begin
      line_flags = '1;
      req_flags  = '1;
      if (SKIP_EMPTY != 0) begin
         for (int b = 0; b < BEATS; b++) begin
            line_flags[b] = beat_has_bytes(line_mask_q[b*BEAT_MASK_W +: BEAT_MASK_W]);
            req_flags[b]  = beat_has_bytes(io_req_bits_mask[b*BEAT_MASK_W +: BEAT_MASK_W]);
         end
      end
   end

   // Next beat of the line in flight; none_left marks the current beat as last.
   store_line_next_beat #(.BEATS(BEATS), .IW(IW)) u_next (
      .flags     (line_flags),
      .idx       (idx_q),
      .inclusive (1'b0),
      .next_idx  (next_idx),
      .none_left (last_beat)
   );

   // First beat of the incoming line; none_left means nothing to emit.
   store_line_next_beat #(.BEATS(BEATS), .IW(IW)) u_first (
      .flags     (req_flags),
      .idx       ('0),
      .inclusive (1'b1),
      .next_idx  (first_idx),
      .none_left (req_empty)
   );

   always_comb begin
      cur_beat.data = line_data_q[idx_q*BEAT_DATA_W +: BEAT_DATA_W];
      cur_beat.mask = line_mask_q[idx_q*BEAT_MASK_W +: BEAT_MASK_W];
   end

   assign io_deq_valid     = (state_q == ST_SEND);
   assign io_deq_bits_data = cur_beat.data;
   assign io_deq_bits_mask = cur_beat.mask;

   assign beat_hs = io_deq_valid && io_deq_ready;
   assign last_hs = beat_hs && last_beat;

   // Reset gates ready directly so nothing is accepted while reset is held.
   assign io_req_ready = reset && ((state_q == ST_IDLE) || last_hs);
   assign accept       = io_req_valid && io_req_ready;
   assign io_done      = last_hs || (accept && req_empty);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         line_data_q <= '0;
         line_mask_q <= '0;
      end else if (accept) begin
         // An accepted all-empty line is consumed on the spot and leaves us idle.
         line_data_q <= io_req_bits_data;
         line_mask_q <= io_req_bits_mask;
         idx_q       <= first_idx;
         state_q     <= req_empty ? ST_IDLE : ST_SEND;
      end else if (last_hs) begin
         state_q <= ST_IDLE;
      end else if (beat_hs) begin
         idx_q <= next_idx;
      end
   end

endmodule

// File: doc/store_line_serializer.md
STORE_LINE_SERIALIZER -- requirements
Module: store_line_serializer

Interface
REQ-001 Parameter BEATS, default 4: number of 64-bit beats per line; legal values are 2, 4 and 8.
REQ-002 Parameter SKIP_EMPTY, default 1: when 1, beats with an all-zero byte mask are not emitted.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 io_req_ready  output  1  block can accept a line this cycle.
REQ-006 io_req_valid  input  1  line request present.
REQ-007 io_req_bits_data  input  64*BEATS  line data; beat i occupies bits [64i+63:64i].
REQ-008 io_req_bits_mask  input  8*BEATS  byte enables; beat i occupies bits [8i+7:8i].
REQ-009 io_deq_ready  input  1  downstream beat queue can accept a beat.
REQ-010 io_deq_valid  output  1  beat present.
REQ-011 io_deq_bits_mask  output  8  byte mask of the current beat.
REQ-012 io_deq_bits_data  output  64  data of the current beat.
REQ-013 io_done  output  1  one-cycle pulse on the handshake of the final beat of a line, or on acceptance of a line that emits no beats.

Function
REQ-014 States: IDLE and SEND; reset state is IDLE.
REQ-015 In IDLE, io_req_ready is 1 and io_deq_valid is 0.
REQ-016 A request is accepted when io_req_valid and io_req_ready are both 1; the data and mask are captured into internal line registers on that edge.
REQ-017 On acceptance, the beat index loads the lowest emittable beat: beat 0 when SKIP_EMPTY=0, otherwise the lowest beat with a non-zero mask.
REQ-018 If SKIP_EMPTY=1 and the entire mask is zero, the line is consumed, io_done pulses in the acceptance cycle, no beat is emitted, and the state remains IDLE.
REQ-019 Latency: for a line accepted at edge N, the first beat is valid in cycle N+1; no combinational path exists from io_req_* to io_deq_*.
REQ-020 In SEND, io_deq_valid is 1 and io_deq_bits_* reflect the registered line at the current index.
REQ-021 io_deq_valid and io_deq_bits_* remain stable until the beat handshake occurs.
REQ-022 On a beat handshake (io_deq_valid and io_deq_ready both 1), the index advances to the next emittable beat above the current index, in ascending order; skipped beats consume no cycles.
REQ-023 A beat is last when no emittable beat exists above its index; with SKIP_EMPTY=0, the last beat is BEATS-1.
REQ-024 io_req_ready is 1 in IDLE, or in SEND during the cycle in which the last beat handshakes.
REQ-025 If a new request is accepted in the same cycle as the last-beat handshake, the block stays in SEND with the new line, giving back-to-back lines with no bubble.
REQ-026 If the last beat handshakes and no request is accepted in that cycle, the next state is IDLE.
REQ-027 The index register is ceil(log2(BEATS)) bits wide; it never wraps within a line.
REQ-028 A mask of 0x00 on an emitted beat is legal only when SKIP_EMPTY=0.
REQ-029 io_deq_ready held at 0 stalls the block indefinitely with no loss or reordering of beats.

Reset
REQ-030 Reset assertion immediately forces the state to IDLE, the index to 0 and the line registers to 0, regardless of the clock.
REQ-031 While in reset: io_deq_valid=0, io_done=0, io_req_ready=0, io_deq_bits_*=0.
REQ-032 A line in flight when reset asserts is discarded; after reset releases, operation resumes from IDLE.
REQ-033 Reset deassertion is synchronized externally; the block makes no internal synchronization assumption beyond an asynchronous assert.

Structure
REQ-034 A shared package holds the constants BEAT_DATA_W=64 and BEAT_MASK_W=8, and the beat struct type {mask[7:0], data[63:0]} packed as data-over-mask, matching the beat queue word layout.
REQ-035 The block has one sub-module, store_line_next_beat: a combinational find-next-set over the per-beat non-zero flags above a given index, returning the next index and a none-left flag.
REQ-036 The output connects directly to an existing 8-entry beat queue's enq port; the block contains no internal FIFO.

Verification
REQ-037 BEATS=4, SKIP_EMPTY=0, mask 0xFFFFFFFF, data beats 0x11..11/0x22..22/0x33..33/0x44..44, io_deq_ready=1 -> 4 beats on consecutive cycles N+1..N+4, each with mask 0xFF, in that data order; io_done in cycle N+4.
REQ-038 SKIP_EMPTY=1, mask 0x0F00F000 -> exactly 2 beats, beat 1 with mask 0xF0 and beat 3 with mask 0x0F, on consecutive cycles.
REQ-039 SKIP_EMPTY=1, mask 0x00000000 -> io_done pulses in the acceptance cycle, io_deq_valid stays 0, and io_req_ready remains 1.
REQ-040 Two lines offered back-to-back with io_deq_ready=1 -> 8 beats with no idle cycle; the second acceptance coincides with the first line's last beat handshake.
REQ-041 io_deq_ready toggled randomly with a 30% stall rate -> beat data stable during stalls, and the beat sequence matches a reference model exactly.
REQ-042 reset driven to 0 mid-line after beat 1 -> io_deq_valid drops without waiting for a clock edge; after release, the next line's first beat is its own beat 0 with no stale data.
